servo_pwm_bank: RTL and testbench
=================================

# servo_pwm_bank

Parametrised N-channel servo PWM controller with an SPI-addressed register bank, run entirely in the system clock domain. It generalises the fixed 8-channel SPI-to-servo design:

- configurable channel count and PWM timing;
- SPI readback;
- auto-increment burst access;
- double-buffered duty registers that commit only at frame boundaries, so servo pulses never glitch.

## Interface
- `N_CH`, 8: number of PWM channels, 1..127; duty registers at addresses 0..N_CH-1.
- `TICK_DIV`, 50: clk cycles per PWM tick.
- `FRAME_TICKS`, 20000: ticks per PWM frame.
- `MIN_TICKS`, 1000: pulse width at duty 0.
- `STEP_TICKS`, 4: extra ticks per duty LSB. Elaboration must fail unless MIN_TICKS + 255*STEP_TICKS < FRAME_TICKS.
- `RESET_DUTY`, 8'd128: reset value of every duty register.
- `clk` input 1: the single clock. One clock; reset is asynchronous and active-low.
- `rst_n` input 1: asynchronous active-low reset.
- `cs` input 1: SPI chip select, active low, asynchronous to clk.
- `sck` input 1: SPI clock, mode 0, asynchronous to clk.
- `mosi` input 1: SPI data in, MSB first.
- `miso` output 1: SPI data out, MSB first; 0 when not driving read data.
- `pwmOut` output N_CH: registered servo pulse outputs.

## Operation
- `cs`, `sck` and `mosi` each pass through a 2-flop synchroniser. Edges of synchronised `sck` are detected in clk. Requirement: f_clk ≥ 8·f_sck.
- SPI FSM states:
  - IDLE (cs high) → CMD on cs falling.
  - CMD → DATA after 8 bits.
  - DATA → DATA every 8 bits.
  - any state → IDLE on cs rising.
- Command byte: bit7 = 1 write / 0 read; bits[6:0] = address. Address 0x7F = CTRL, where bit0 = global enable and bits[7:1] read as 0.
- Write: each completed data byte is stored to shadow[addr] (or CTRL), then addr increments.
- Read: on the sck falling edge that begins each data byte, load the shift register with shadow[addr] (or CTRL), drive its MSB on `miso`, then increment addr. Each following falling edge shifts out the next bit.
- Address is 7 bits and wraps 0x7F → 0x00.
- Addresses N_CH..0x7E: writes are ignored, reads return 0x00.
- A partial byte at cs rising is discarded. cs rising mid-operation never corrupts a register.
- PWM datapath:
  - A prescaler counts 0..TICK_DIV-1.
  - The frame counter advances once per tick, over 0..FRAME_TICKS-1.
  - On the last clk cycle of the frame, every shadow duty copies into its active register and CTRL.enable copies into active_enable.
- Per channel, width = MIN_TICKS + duty·STEP_TICKS, computed at full width with no truncation. pwmOut[i] is registered high while active_enable && frame_cnt < width[i].
- Reset values:
  - shadow and active duty = RESET_DUTY;
  - CTRL and active_enable = 0;
  - counters = 0;
  - pwmOut = 0, miso = 0;
  - FSM = IDLE.
- Reset asserted mid-frame or mid-transfer forces all of these reset values immediately, asynchronously.

## Timing
- SPI pin edge to detected edge: 3 clk (2 synchroniser flops + 1 edge register).
- Write byte to shadow update: 1 clk after the detected 8th rising edge.
- Shadow to output: takes effect in the first full frame after the commit cycle. A write landing in the same clk as the commit cycle is not committed until the next frame.
- `miso` updates 1 clk after each detected sck falling edge.
- `pwmOut` rises 1 clk after frame_cnt returns to 0. Pulse length is exactly width·TICK_DIV clk cycles.
- Setting or clearing enable affects output only from the next frame start. No runt pulses.

## Structure
- `servo_pwm_pkg` holds:
  - the SPI state enum (IDLE, CMD, DATA);
  - CMD_WRITE_BIT = 7;
  - CTRL_ADDR = 7'h7F;
  - CTRL_EN_BIT = 0.
- One sub-module, `spi_slave_sync`, contains:
  - the synchronisers and edge detection;
  - bit counter, shift registers and FSM.
- Its interface to the bank:
  - `cmd_valid`, `is_write`, `addr`;
  - `wr_valid`, `wr_data`;
  - `rd_req`, `rd_data`.
- The PWM counters, register bank and compare logic live in the top module.

## Test plan
Benches use TICK_DIV=1, FRAME_TICKS=600, MIN_TICKS=40, STEP_TICKS=2, N_CH=4.

1. Reset, then run 2 frames → pwmOut = 0000 throughout and miso = 0.
2. Write CTRL = 0x01, then run 2 frames → every channel is high for exactly 40+128·2 = 296 clk per frame, starting at the first frame after the write.
3. Burst write: cmd 0x80, data 0x00, 0xFF, 0x10, 0x20 → next frame widths are 40, 550, 72, 104 clk, and the previous frame is unchanged.
4. Burst read: cmd 0x01, then 3 dummy bytes → miso returns 0xFF, 0x10, 0x20. A read of address 0x05 returns 0x00.
5. Raise cs after 5 bits of a write data byte to channel 0 → shadow[0] is unchanged; the next transaction decodes correctly.
6. Write channel 1 timed so the byte completes in the commit cycle → the new width appears one frame later. Separately, assert rst_n low mid-pulse → pwmOut drops to 0 and readback shows 0x80 everywhere.

Source files
------------

// File: rtl/servo_pwm_pkg.sv
// servo_pwm_pkg: shared SPI state encoding and register map constants for the servo PWM bank
package servo_pwm_pkg;
  typedef enum logic [1:0] {IDLE, CMD, DATA} spi_state_t;
  localparam int CMD_WRITE_BIT = 7;
  localparam logic [6:0] CTRL_ADDR = 7'h7F;
  localparam int CTRL_EN_BIT = 0;
endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: mode-0 SPI slave oversampled in clk, emits command/byte strobes and shifts read data out
module spi_slave_sync
  import servo_pwm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       cmd_valid,
  output logic       is_write,
  output logic [6:0] addr,
  output logic       wr_valid,
  output logic [7:0] wr_data,
  output logic       rd_req,
  input  logic [7:0] rd_data
);
  logic [2:0] cs_s, sck_s;
  logic [1:0] mosi_s;
  logic rise, fall, cs_hi, done, wr_mode;
  logic [2:0] bit_cnt;
  logic [6:0] sh_in;
  logic [7:0] sh_out, rx_byte;
  spi_state_t state, state_n;
  assign cs_hi = cs_s[2];
  assign rx_byte = {sh_in, mosi_s[1]};
  assign done = rise && bit_cnt == 3'd7 && !cs_hi;
  assign cmd_valid = done && state == CMD;
  assign is_write = rx_byte[CMD_WRITE_BIT];
  assign addr = rx_byte[6:0];
  assign wr_valid = done && state == DATA;
  assign wr_data = rx_byte;
  assign rd_req = fall && bit_cnt == 3'd0 && state == DATA && !cs_hi;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cs_s <= 3'b111;
      sck_s <= '0;
      mosi_s <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      cs_s <= {cs_s[1:0], cs};
      sck_s <= {sck_s[1:0], sck};
      mosi_s <= {mosi_s[0], mosi};
      rise <= sck_s[1] & ~sck_s[2];
      fall <= ~sck_s[1] & sck_s[2];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = cs_hi ? IDLE : (state == IDLE) ? CMD : cmd_valid ? DATA : state;
  // A partial byte dies with cs: the bit counter restarts and nothing is strobed.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bit_cnt <= '0;
      sh_in <= '0;
      sh_out <= '0;
      miso <= 1'b0;
      wr_mode <= 1'b0;
    end else begin
      if (cs_hi || state == IDLE) bit_cnt <= '0;
      else if (rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        sh_in <= rx_byte[6:0];
      end
      if (cmd_valid) wr_mode <= is_write;
      if (cs_hi) begin
        sh_out <= '0;
        miso <= 1'b0;
      end else if (rd_req && !wr_mode) begin
        sh_out <= rd_data;
        miso <= rd_data[7];
      end else if (fall && state == DATA && !wr_mode) begin
        sh_out <= {sh_out[6:0], 1'b0};
        miso <= sh_out[6];
      end
    end
endmodule

// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: N-channel servo PWM with SPI register bank and frame-synchronous duty commit
module servo_pwm_bank
  import servo_pwm_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int TICK_DIV = 50,
  parameter int FRAME_TICKS = 20000,
  parameter int MIN_TICKS = 1000,
  parameter int STEP_TICKS = 4,
  parameter logic [7:0] RESET_DUTY = 8'd128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cs,
  input  logic            sck,
  input  logic            mosi,
  output logic            miso,
  output logic [N_CH-1:0] pwmOut
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int FW = FRAME_TICKS > 1 ? $clog2(FRAME_TICKS) : 1;
  if (MIN_TICKS + 255 * STEP_TICKS >= FRAME_TICKS) begin : g_bad_timing
    $error("servo_pwm_bank: MIN_TICKS + 255*STEP_TICKS must be below FRAME_TICKS");
  end
  if (N_CH < 1 || N_CH > 127) begin : g_bad_nch
    $error("servo_pwm_bank: N_CH must be 1..127");
  end
  logic [PW-1:0] pre;
  logic [FW-1:0] frame_cnt;
  logic tick, commit, ctrl_en, active_en, wr_mode;
  logic [7:0] shadow [N_CH];
  logic [7:0] active [N_CH];
  logic [6:0] ptr, addr;
  logic cmd_valid, is_write, wr_valid, rd_req;
  logic [7:0] wr_data, rd_data;
  spi_slave_sync u_spi (
    .clk(clk), .rst_n(rst_n), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso),
    .cmd_valid(cmd_valid), .is_write(is_write), .addr(addr),
    .wr_valid(wr_valid), .wr_data(wr_data), .rd_req(rd_req), .rd_data(rd_data)
  );
  assign tick = pre == PW'(TICK_DIV - 1);
  assign commit = tick && frame_cnt == FW'(FRAME_TICKS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre <= '0;
      frame_cnt <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) frame_cnt <= commit ? '0 : frame_cnt + 1'b1;
    end
  // Commit samples the pre-write shadow, so a byte landing in the commit cycle waits a frame.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      wr_mode <= 1'b0;
      ctrl_en <= 1'b0;
      active_en <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        shadow[i] <= RESET_DUTY;
        active[i] <= RESET_DUTY;
      end
    end else begin
      if (cmd_valid) begin
        ptr <= addr;
        wr_mode <= is_write;
      end else if ((wr_valid && wr_mode) || (rd_req && !wr_mode)) ptr <= ptr + 7'd1;
      if (wr_valid && wr_mode && ptr == CTRL_ADDR) ctrl_en <= wr_data[CTRL_EN_BIT];
      for (int i = 0; i < N_CH; i++) begin
        if (wr_valid && wr_mode && ptr == 7'(i)) shadow[i] <= wr_data;
        if (commit) active[i] <= shadow[i];
      end
      if (commit) active_en <= ctrl_en;
    end
  always_comb begin
    rd_data = ptr == CTRL_ADDR ? 8'(ctrl_en) : 8'h00;
    for (int i = 0; i < N_CH; i++)
      if (ptr == 7'(i)) rd_data = shadow[i];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pwmOut <= '0;
    else
      for (int i = 0; i < N_CH; i++)
        pwmOut[i] <= active_en &&
          (32'(frame_cnt) < 32'(MIN_TICKS) + 32'(active[i]) * 32'(STEP_TICKS));
endmodule

// File: tb/tb_servo_pwm_bank.sv
// tb_servo_pwm_bank: directed vectors for SPI register access and frame-accurate pulse widths
module tb_servo_pwm_bank;
  logic clk = 1'b0, rst_n = 1'b0, cs = 1'b1, sck = 1'b0, mosi = 1'b0;
  logic miso;
  logic [3:0] pwm;
  int checks = 0, failures = 0;
  int tc;
  logic [7:0] rx, dummy;
  typedef struct { logic [6:0] addr; logic [7:0] exp; } rd_vec_t;
  rd_vec_t rv [8];
  logic [7:0] burst_exp [3];

  always #5 clk = ~clk;

  servo_pwm_bank #(.N_CH(4), .TICK_DIV(1), .FRAME_TICKS(600), .MIN_TICKS(40),
                   .STEP_TICKS(2), .RESET_DUTY(8'd128)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso), .pwmOut(pwm)
  );

  // Reference frame position: mirrors the counter value the DUT should hold after each edge.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tc <= 0;
    else tc <= (tc == 599) ? 0 : tc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_tc(input int v);
    int n = 0;
    while (tc != v && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL wait_tc: frame position %0d never reached", v);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit align, output logic [7:0] r);
    r = '0;
    for (int b = 7; b > 7 - nbits; b--) begin
      mosi = tx[b];
      repeat (6) @(negedge clk);
      r[b] = miso;
      if (align && b == 0) wait_tc(596);
      sck = 1'b1;
      repeat (6) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic spi_start;
    cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_end;
    repeat (6) @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_write1(input logic [7:0] cmd, input logic [7:0] d);
    logic [7:0] r;
    spi_start;
    spi_byte(cmd, 8, 1'b0, r);
    spi_byte(d, 8, 1'b0, r);
    spi_end;
  endtask

  task automatic spi_read(input logic [6:0] a, output logic [7:0] r);
    logic [7:0] t;
    spi_start;
    spi_byte({1'b0, a}, 8, 1'b0, t);
    spi_byte(8'h00, 8, 1'b0, r);
    spi_end;
  endtask

  task automatic check_frame(input string nm, input int e0, input int e1, input int e2,
                             input int e3, input logic [3:0] ef);
    int w [4];
    int e [4];
    logic [3:0] first;
    e = '{e0, e1, e2, e3};
    w = '{0, 0, 0, 0};
    wait_tc(1);
    first = pwm;
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < 4; c++) w[c] += int'(pwm[c]);
      @(negedge clk);
    end
    check({nm, "_start"}, 32'(first), 32'(ef));
    for (int c = 0; c < 4; c++) check($sformatf("%s_ch%0d", nm, c), w[c], e[c]);
  endtask

  initial begin
    rv[0] = '{7'h00, 8'h00};
    rv[1] = '{7'h01, 8'hFF};
    rv[2] = '{7'h02, 8'h10};
    rv[3] = '{7'h03, 8'h20};
    rv[4] = '{7'h04, 8'h00};
    rv[5] = '{7'h05, 8'h00};
    rv[6] = '{7'h7E, 8'h00};
    rv[7] = '{7'h7F, 8'h01};
    burst_exp = '{8'hFF, 8'h10, 8'h20};

    repeat (3) @(negedge clk);
    check("reset_pwm", 32'(pwm), 0);
    check("reset_miso", 32'(miso), 0);
    rst_n = 1'b1;

    check_frame("idle_f0", 0, 0, 0, 0, 4'h0);
    check_frame("idle_f1", 0, 0, 0, 0, 4'h0);
    check("idle_miso", 32'(miso), 0);

    wait_tc(1);
    fork
      check_frame("en_write_frame", 0, 0, 0, 0, 4'h0);
      spi_write1(8'hFF, 8'h01);
    join
    check_frame("en_f1", 296, 296, 296, 296, 4'hF);
    check_frame("en_f2", 296, 296, 296, 296, 4'hF);

    wait_tc(1);
    fork
      check_frame("burst_prev", 296, 296, 296, 296, 4'hF);
      begin
        spi_start;
        spi_byte(8'h80, 8, 1'b0, dummy);
        spi_byte(8'h00, 8, 1'b0, dummy);
        spi_byte(8'hFF, 8, 1'b0, dummy);
        spi_byte(8'h10, 8, 1'b0, dummy);
        spi_byte(8'h20, 8, 1'b0, dummy);
        spi_end;
      end
    join
    check_frame("burst_new", 40, 550, 72, 104, 4'hF);

    spi_write1(8'h85, 8'hAA);
    for (int i = 0; i < 8; i++) begin
      spi_read(rv[i].addr, rx);
      check($sformatf("read_%02h", rv[i].addr), 32'(rx), 32'(rv[i].exp));
    end

    spi_start;
    spi_byte(8'h01, 8, 1'b0, dummy);
    for (int i = 0; i < 3; i++) begin
      spi_byte(8'h00, 8, 1'b0, rx);
      check($sformatf("burst_read_%0d", i), 32'(rx), 32'(burst_exp[i]));
    end
    spi_end;
    check("miso_after_read", 32'(miso), 0);

    spi_start;
    spi_byte(8'h7F, 8, 1'b0, dummy);
    spi_byte(8'h00, 8, 1'b0, rx);
    check("wrap_ctrl", 32'(rx), 32'h01);
    spi_byte(8'h00, 8, 1'b0, rx);
    check("wrap_ch0", 32'(rx), 32'h00);
    spi_end;

    spi_start;
    spi_byte(8'h80, 8, 1'b0, dummy);
    spi_byte(8'h55, 5, 1'b0, dummy);
    spi_end;
    spi_read(7'h00, rx);
    check("partial_ch0", 32'(rx), 32'h00);
    spi_write1(8'h80, 8'h33);
    spi_read(7'h00, rx);
    check("after_partial_ch0", 32'(rx), 32'h33);

    wait_tc(1);
    fork
      begin
        spi_start;
        spi_byte(8'h81, 8, 1'b0, dummy);
        spi_byte(8'h40, 8, 1'b1, dummy);
        spi_end;
      end
      begin
        wait_tc(596);
        @(negedge clk);
        check_frame("commit_race_f1", 142, 550, 72, 104, 4'hF);
      end
    join
    check_frame("commit_race_f2", 142, 168, 72, 104, 4'hF);

    wait_tc(50);
    check("pre_reset_pwm", 32'(pwm), 32'hF);
    rst_n = 1'b0;
    #1;
    check("async_reset_pwm", 32'(pwm), 0);
    check("async_reset_miso", 32'(miso), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      spi_read(7'(a), rx);
      check($sformatf("post_reset_ch%0d", a), 32'(rx), 32'h80);
    end
    spi_read(7'h7F, rx);
    check("post_reset_ctrl", 32'(rx), 32'h00);
    check_frame("post_reset_frame", 0, 0, 0, 0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
